cla_addsub_pipe: RTL
====================

Name: cla_addsub_pipe

Overview:
- Parametrised, pipelined successor to the team's 4-bit carry-lookahead adder.
- Chains WIDTH/4 lookahead groups of 4 bits each and registers the inter-group carry every GRP_PER_STAGE groups.
- Adds subtract and signed-saturating modes, status flags, and a valid/ready handshake.
- Sits in the execute datapath in front of the writeback and flag registers, for wide adds that would not close timing in a single cycle.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of 4*GRP_PER_STAGE, otherwise elaboration fails.
- GRP_PER_STAGE, 1, number of 4-bit lookahead groups evaluated per pipeline stage.
- NSTAGES (derived, not overridable), WIDTH/(4*GRP_PER_STAGE), pipeline depth and latency in cycles.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operands and mode valid
- in_ready  out  1  block accepts on clk edge when in_valid & in_ready
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- cin  in  1  carry-in, used in ADD mode only
- mode  in  2  00 ADD, 01 SUB, 10 SADD, 11 SSUB
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts
- sum  out  WIDTH  result
- cout  out  1  carry out of the MSB group
- ovfl  out  1  signed overflow
- zero  out  1  sum == 0
- neg  out  1  sum[WIDTH-1]

Behaviour:
- Reset: asynchronous, while rst_n is low.
  - All stage valid bits, sum, cout, ovfl, zero and neg go to 0.
  - in_ready goes to 1 once the block is out of reset.
  - In-flight operations are discarded; there is no partial output after reset releases.
- Operand formation at stage 0:
  - ADD: B' = b, c0 = cin.
  - SUB: B' = ~b, c0 = 1.
  - SADD: B' = b, c0 = 0.
  - SSUB: B' = ~b, c0 = 1.
- Per group g (bits 4g+3..4g):
  - G = A & B', P = A ^ B'.
  - Group carries use lookahead: c[i+1] = G[i] | P[i]&c[i].
  - Sum bits = P ^ c.
- Pipelining:
  - Stage k computes groups k*GRP_PER_STAGE .. (k+1)*GRP_PER_STAGE-1 using the carry registered by stage k-1.
  - Upper operand slices and mode are delayed (skewed) to arrive with their carry.
  - Completed lower sum slices are delayed (deskewed) so all bits of a result exit together.
  - The last stage register drives the outputs.
- Flags, computed in the last stage:
  - cout = carry out of bit WIDTH-1. For SUB this is the true carry of A+~B+1, i.e. 1 means no borrow.
  - ovfl = carry into MSB ^ carry out of MSB.
  - In SADD/SSUB with ovfl=1, sum saturates:
    - to 0111..1 if A[WIDTH-1]=0;
    - to 1000..0 if A[WIDTH-1]=1.
  - After saturation, ovfl stays 1 and cout reports the unsaturated carry.
  - zero and neg reflect the final (possibly saturated) sum.
- Latency: a result accepted at edge T appears with out_valid=1 after edge T+NSTAGES, provided there are no stalls.
- Throughput: one operation per cycle.
- Handshake (global stall):
  - advance = ~out_valid | out_ready.
  - in_ready = advance.
  - When advance=0, every stage register, including outputs, holds its value.
  - Bubbles are not compressed.
- Output stability: while out_valid=1 and out_ready=0, sum and all flags hold stable.
- Simultaneous accept-and-drain: when out_valid & out_ready & in_valid all hold, the new input enters stage 0 on the same edge that the output is consumed.
- Idle: when in_valid=0 and advance=1, a bubble (valid=0) is inserted. Data registers may update, but flags have no meaning while out_valid=0.
- Degenerate case NSTAGES=1: the block behaves as a registered single-cycle adder with the same handshake.

Test Plan (WIDTH=16, GRP_PER_STAGE=1, so latency is 4):
- Reset/basic add: reset, then ADD a=0x1234 b=0x4321 cin=1. Four cycles later expect sum=0x5556, cout=0, ovfl=0, zero=0, neg=0.
- Carry ripple across stages: ADD a=0xFFFF b=0x0000 cin=1 -> sum=0x0000, cout=1, zero=1, ovfl=0. Then SUB a=0x0005 b=0x0007 -> sum=0xFFFE, cout=0, neg=1.
- Saturation:
  - SADD 0x7FFF+0x0001 -> sum=0x7FFF, ovfl=1.
  - SSUB 0x8000-0x0001 -> sum=0x8000, ovfl=1, neg=1.
  - Plain ADD 0x7FFF+0x0001 -> sum=0x8000, ovfl=1.
- Backpressure: stream 6 back-to-back ADDs (i + 0x0100, i=0..5) while holding out_ready=0 from cycle 5 to 8.
  - Expect in_ready=0 during the stall.
  - Expect outputs held stable.
  - Expect all 6 results in order with no loss or duplication.
- Reset mid-flight: assert rst_n=0 with 3 operations in flight -> all outputs 0 immediately. After release, no out_valid until new inputs arrive 4 cycles earlier.
- Parameter sweep: WIDTH=32 with GRP_PER_STAGE=2 (latency 4) and WIDTH=8 with GRP_PER_STAGE=2 (latency 1), random operands and modes checked against a reference model.

Source files
------------

// File: rtl/cla_addsub_pipe.sv
// cla_addsub_pipe
//   Pipelined carry-lookahead adder/subtractor with signed saturation and
//   status flags. The operand is split into 4-bit lookahead groups. Each
//   pipeline stage evaluates GRP_PER_STAGE groups and registers the carry out
//   of its slice for the next stage. Upper operand slices travel down the
//   pipe with their carry, and finished lower sum slices travel alongside
//   them, so every bit of a result leaves the block together.
//
//   Rank 0 captures the formed operands (A, B', c0, mode). Ranks 1..NSTAGES-1
//   each add one slice. The final stage adds the top slice, computes the
//   flags and saturation, and loads the output register. Latency is
//   therefore NSTAGES cycles from the accepting edge.
//
// Ports
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   in_valid  in   operands/mode valid
//   in_ready  out  operation accepted on an edge where in_valid & in_ready
//   a, b      in   WIDTH-bit operands
//   cin       in   carry-in (ADD mode only)
//   mode      in   00 ADD, 01 SUB, 10 SADD, 11 SSUB
//   out_valid out  result valid
//   out_ready in   downstream accepts the result
//   sum       out  WIDTH-bit result (saturated in SADD/SSUB)
//   cout      out  carry out of the MSB (unsaturated)
//   ovfl      out  signed overflow
//   zero      out  sum == 0
//   neg       out  sum[WIDTH-1]
module cla_addsub_pipe #(
    parameter int WIDTH         = 16,
    parameter int GRP_PER_STAGE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovfl,
    output logic             zero,
    output logic             neg
);

    localparam int SW      = 4 * GRP_PER_STAGE;
    localparam int NSTAGES = WIDTH / SW;
    localparam int LAST_LO = (NSTAGES - 1) * SW;

    if (GRP_PER_STAGE < 1 || WIDTH < SW || (WIDTH % SW) != 0) begin : g_bad_width
        $error("cla_addsub_pipe: WIDTH must be a non-zero multiple of 4*GRP_PER_STAGE");
    end

    // One slice of SW bits built from 4-bit lookahead groups.
    // Returns {carry_out, sum_slice}.
    function automatic logic [SW:0] cla_slice(input logic [SW-1:0] fa,
                                              input logic [SW-1:0] fb,
                                              input logic          fc);
        logic [SW-1:0] g;
        logic [SW-1:0] p;
        logic [SW:0]   c;
        g    = fa & fb;
        p    = fa ^ fb;
        c    = '0;
        c[0] = fc;
        for (int k = 0; k < GRP_PER_STAGE; k++) begin
            c[4*k+1] = g[4*k] | (p[4*k] & c[4*k]);
            c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & c[4*k]);
            c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
                     | (p[4*k+2] & p[4*k+1] & p[4*k] & c[4*k]);
            c[4*k+4] = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                     | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k])
                     | (p[4*k+3] & p[4*k+2] & p[4*k+1] & p[4*k] & c[4*k]);
        end
        return {c[SW], p ^ c[SW-1:0]};
    endfunction

    // Clamp to the signed extreme on the side of A's sign.
    function automatic logic [WIDTH-1:0] saturate(input logic [WIDTH-1:0] raw,
                                                  input logic             a_msb,
                                                  input logic             sat);
        if (!sat) return raw;
        return a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    endfunction

    logic               w_adv;
    logic [NSTAGES-1:0] r_vld;
    logic [NSTAGES-1:0] r_c;
    logic [NSTAGES-1:0] w_c;
    logic [WIDTH-1:0]   r_a    [NSTAGES];
    logic [WIDTH-1:0]   r_bp   [NSTAGES];
    logic [WIDTH-1:0]   r_psum [NSTAGES];
    logic [1:0]         r_mode [NSTAGES];
    logic [WIDTH-1:0]   w_a    [NSTAGES];
    logic [WIDTH-1:0]   w_bp   [NSTAGES];
    logic [WIDTH-1:0]   w_psum [NSTAGES];
    logic [1:0]         w_mode [NSTAGES];

    logic [SW:0]        w_fslc;
    logic [WIDTH-1:0]   w_raw;
    logic               w_cout;
    logic               w_ovfl;

    logic               r_out_vld;
    logic [WIDTH-1:0]   r_sum;
    logic               r_cout;
    logic               r_ovfl;
    logic               r_zero;
    logic               r_neg;

    // Global stall: everything moves only when the output slot is free.
    assign w_adv    = ~r_out_vld | out_ready;
    assign in_ready = w_adv;

    // Rank 0 operand formation, then one slice per rank; upper operand
    // bits and mode ride along untouched, finished lower sum bits too.
    always_comb begin
        w_a[0]    = a;
        w_bp[0]   = mode[0] ? ~b : b;
        w_c       = '0;
        w_c[0]    = (mode == 2'b00) ? cin : mode[0];
        w_mode[0] = mode;
        w_psum[0] = '0;
        for (int j = 1; j < NSTAGES; j++) begin
            logic [SW:0] v_slc;
            v_slc     = cla_slice(r_a[j-1][(j-1)*SW +: SW], r_bp[j-1][(j-1)*SW +: SW], r_c[j-1]);
            w_a[j]    = r_a[j-1];
            w_bp[j]   = r_bp[j-1];
            w_mode[j] = r_mode[j-1];
            w_c[j]    = v_slc[SW];
            w_psum[j] = r_psum[j-1];
            w_psum[j][(j-1)*SW +: SW] = v_slc[SW-1:0];
        end
    end

    // Final stage: top slice, flags and saturation.
    always_comb begin
        w_fslc = cla_slice(r_a[NSTAGES-1][LAST_LO +: SW], r_bp[NSTAGES-1][LAST_LO +: SW],
                           r_c[NSTAGES-1]);
        w_raw  = r_psum[NSTAGES-1];
        w_raw[LAST_LO +: SW] = w_fslc[SW-1:0];
        w_cout = w_fslc[SW];
        // Carry into the MSB recovered from sum = P ^ c.
        w_ovfl = (w_raw[WIDTH-1] ^ r_a[NSTAGES-1][WIDTH-1] ^ r_bp[NSTAGES-1][WIDTH-1]) ^ w_cout;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld     <= '0;
            r_out_vld <= 1'b0;
            r_sum     <= '0;
            r_cout    <= 1'b0;
            r_ovfl    <= 1'b0;
            r_zero    <= 1'b0;
            r_neg     <= 1'b0;
        end else if (w_adv) begin
            r_vld[0] <= in_valid;
            for (int j = 1; j < NSTAGES; j++) begin
                r_vld[j] <= r_vld[j-1];
            end
            r_out_vld <= r_vld[NSTAGES-1];
            r_sum     <= saturate(w_raw, r_a[NSTAGES-1][WIDTH-1], r_mode[NSTAGES-1][1] & w_ovfl);
            r_cout    <= w_cout;
            r_ovfl    <= w_ovfl;
            r_zero    <= (saturate(w_raw, r_a[NSTAGES-1][WIDTH-1],
                                   r_mode[NSTAGES-1][1] & w_ovfl) == '0);
            r_neg     <= saturate(w_raw, r_a[NSTAGES-1][WIDTH-1],
                                  r_mode[NSTAGES-1][1] & w_ovfl) >> (WIDTH-1) != '0;
        end
    end

    // Datapath ranks carry no reset; their valid bits qualify them.
    always_ff @(posedge clk) begin
        if (w_adv) begin
            for (int j = 0; j < NSTAGES; j++) begin
                r_a[j]    <= w_a[j];
                r_bp[j]   <= w_bp[j];
                r_psum[j] <= w_psum[j];
                r_mode[j] <= w_mode[j];
                r_c[j]    <= w_c[j];
            end
        end
    end

    assign out_valid = r_out_vld;
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign ovfl      = r_ovfl;
    assign zero      = r_zero;
    assign neg       = r_neg;

endmodule
